// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control in, instruction-memory handshake, IF/ID outputs.
// Latency: none; this is a bundle of wires.
// Backpressure: imem_ready completes a request; stall freezes the IF/ID register.
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;

    // The fetch stage drives the memory request and the IF/ID outputs.
    modport master (
        input  stall, flush, branch_taken, branch_target, imem_data, imem_ready,
        output imem_req, imem_addr, instruction, instr_pc, instr_valid
    );

    // The surrounding pipeline and instruction memory.
    modport slave (
        output stall, flush, branch_taken, branch_target, imem_data, imem_ready,
        input  imem_req, imem_addr, instruction, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, one-entry skid buffer and IF/ID register; bubbles are all-zero words.
// Latency: a word completing in cycle N is on instruction in cycle N+1; one word per cycle.
// Backpressure: stall holds IF/ID; a word landing during stall is parked and fetch pauses.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_stage_if.master  bus
);

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [31:0] pc;
        logic        vld;
    } ifid_t;

    localparam ifid_t NOOP = '{dat: 32'h0, pc: 32'h0, vld: 1'b0};

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] skid_dat, skid_dat_n;
    ifid_t       ifid, ifid_n;
    logic        done;

    // Request only while out of reset and not holding a parked word.
    assign bus.imem_req  = rst_n && (state == FETCH);
    assign bus.imem_addr = pc;
    assign done          = bus.imem_req && bus.imem_ready;

    assign bus.instruction = ifid.dat;
    assign bus.instr_pc    = ifid.pc;
    assign bus.instr_valid = ifid.vld;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: PC, skid buffer and IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            skid_dat <= 32'h0;
            ifid     <= NOOP;
        end else begin
            pc       <= pc_n;
            skid_dat <= skid_dat_n;
            ifid     <= ifid_n;
        end
    end

    // Next state: branch beats flush beats stall beats normal flow.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        skid_dat_n = skid_dat;
        ifid_n     = ifid;

        if (bus.branch_taken) begin
            // Redirect; anything in flight or parked is younger than the branch.
            pc_n       = bus.branch_target & 32'hFFFF_FFFC;
            ifid_n     = NOOP;
            skid_dat_n = 32'h0;
            state_n    = FETCH;
        end else if (bus.flush) begin
            // PC is left alone so a word completing now is fetched again.
            ifid_n     = NOOP;
            skid_dat_n = 32'h0;
            state_n    = FETCH;
        end else if (bus.stall) begin
            // IF/ID holds; a word finishing now is parked and PC moves past it.
            if (state == FETCH && done) begin
                skid_dat_n = bus.imem_data;
                pc_n       = pc + 32'd4;
                state_n    = HELD;
            end
        end else if (state == HELD) begin
            // Drain the parked word; PC already points one past it.
            ifid_n  = '{dat: skid_dat, pc: pc - 32'd4, vld: 1'b1};
            state_n = FETCH;
        end else if (done) begin
            ifid_n = '{dat: bus.imem_data, pc: pc, vld: 1'b1};
            pc_n   = pc + 32'd4;
        end else begin
            ifid_n = NOOP;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances, default reset PC and a wrapping one.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: imem_ready and stall are driven from the scenario tasks.
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    logic rst_n2;
    int   checks;
    int   errors;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk   (clk),
        .rst_n (rst_n2),
        .bus   (bus2)
    );

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)       return 32'h2001_0005;
        else if (a == 32'h4)  return 32'h0022_1820;
        else if (a == 32'h24) return 32'h0000_0000;
        else                  return {16'hC0DE, a[15:0]};
    endfunction

    always_comb bus.imem_data  = mem_word(bus.imem_addr);
    always_comb bus2.imem_data = mem_word(bus2.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", bus.instruction, 32'h0); end
            checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", bus.instr_pc, 32'h0); end
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
            checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want %h", bus.imem_addr, 32'h0); end
            tick();
        end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL release_req got %b want 1", bus.imem_req); end
    endtask

    task automatic test_sequential;
        tick();
        checks++; if (bus.instruction !== 32'h2001_0005) begin errors++; $display("FAIL seq0_instr got %h want %h", bus.instruction, 32'h2001_0005); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL seq0_pc got %h want %h", bus.instr_pc, 32'h0); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL seq0_valid got %b want 1", bus.instr_valid); end
        tick();
        checks++; if (bus.instruction !== 32'h0022_1820) begin errors++; $display("FAIL seq1_instr got %h want %h", bus.instruction, 32'h0022_1820); end
        checks++; if (bus.instr_pc !== 32'h4) begin errors++; $display("FAIL seq1_pc got %h want %h", bus.instr_pc, 32'h4); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got %b want 1", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr got %h want %h", bus.imem_addr, 32'h8); end
    endtask

    task automatic test_not_ready;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL wait%0d_instr got %h want %h", i, bus.instruction, 32'h0); end
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL wait%0d_valid got %b want 0", i, bus.instr_valid); end
            checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL wait%0d_addr got %h want %h", i, bus.imem_addr, 32'h8); end
        end
        bus.imem_ready = 1'b1;
        tick();
        checks++; if (bus.instruction !== mem_word(32'h8)) begin errors++; $display("FAIL wait_done_instr got %h want %h", bus.instruction, mem_word(32'h8)); end
        checks++; if (bus.instr_pc !== 32'h8) begin errors++; $display("FAIL wait_done_pc got %h want %h", bus.instr_pc, 32'h8); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL wait_done_valid got %b want 1", bus.instr_valid); end
    endtask

    task automatic test_stall;
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.instruction !== mem_word(32'h8)) begin errors++; $display("FAIL stall%0d_instr got %h want %h", i, bus.instruction, mem_word(32'h8)); end
            checks++; if (bus.instr_pc !== 32'h8) begin errors++; $display("FAIL stall%0d_pc got %h want %h", i, bus.instr_pc, 32'h8); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall%0d_req got %b want 0", i, bus.imem_req); end
        end
        bus.stall = 1'b0;
        tick();
        checks++; if (bus.instruction !== mem_word(32'hC)) begin errors++; $display("FAIL unstall_instr got %h want %h", bus.instruction, mem_word(32'hC)); end
        checks++; if (bus.instr_pc !== 32'hC) begin errors++; $display("FAIL unstall_pc got %h want %h", bus.instr_pc, 32'hC); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL unstall_valid got %b want 1", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL unstall_addr got %h want %h", bus.imem_addr, 32'h10); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL unstall_req got %b want 1", bus.imem_req); end
    endtask

    task automatic test_branch_held;
        bus.stall = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL held_req got %b want 0", bus.imem_req); end
        // Branch, flush and stall together: branch wins.
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0103;
        bus.flush         = 1'b1;
        tick();
        bus.branch_taken = 1'b0;
        bus.flush        = 1'b0;
        bus.stall        = 1'b0;
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL br_instr got %h want %h", bus.instruction, 32'h0); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b want 0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr got %h want %h", bus.imem_addr, 32'h100); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL br_req got %b want 1", bus.imem_req); end
        tick();
        checks++; if (bus.instruction !== mem_word(32'h100)) begin errors++; $display("FAIL br_tgt_instr got %h want %h", bus.instruction, mem_word(32'h100)); end
        checks++; if (bus.instr_pc !== 32'h100) begin errors++; $display("FAIL br_tgt_pc got %h want %h", bus.instr_pc, 32'h100); end
    endtask

    task automatic test_flush;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0020;
        tick();
        bus.branch_taken = 1'b0;
        bus.flush        = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL flush_instr got %h want %h", bus.instruction, 32'h0); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL flush_addr got %h want %h", bus.imem_addr, 32'h20); end
        tick();
        checks++; if (bus.instruction !== mem_word(32'h20)) begin errors++; $display("FAIL refetch_instr got %h want %h", bus.instruction, mem_word(32'h20)); end
        checks++; if (bus.instr_pc !== 32'h20) begin errors++; $display("FAIL refetch_pc got %h want %h", bus.instr_pc, 32'h20); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL refetch_valid got %b want 1", bus.instr_valid); end
    endtask

    task automatic test_zero_word;
        tick();
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL zero_instr got %h want %h", bus.instruction, 32'h0); end
        checks++; if (bus.instr_pc !== 32'h24) begin errors++; $display("FAIL zero_pc got %h want %h", bus.instr_pc, 32'h24); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b want 1", bus.instr_valid); end
    endtask

    task automatic test_reset_mid;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL midrst_instr got %h want %h", bus.instruction, 32'h0); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h want %h", bus.instr_pc, 32'h0); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.instr_valid); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b want 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h want %h", bus.imem_addr, 32'h0); end
    endtask

    task automatic test_wrap;
        checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_rst_addr got %h want %h", bus2.imem_addr, 32'hFFFF_FFFC); end
        checks++; if (bus2.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_rst_req got %b want 0", bus2.imem_req); end
        rst_n2 = 1'b1;
        tick();
        checks++; if (bus2.instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap0_pc got %h want %h", bus2.instr_pc, 32'hFFFF_FFFC); end
        checks++; if (bus2.instruction !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap0_instr got %h want %h", bus2.instruction, mem_word(32'hFFFF_FFFC)); end
        tick();
        checks++; if (bus2.instr_pc !== 32'h0) begin errors++; $display("FAIL wrap1_pc got %h want %h", bus2.instr_pc, 32'h0); end
        checks++; if (bus2.instruction !== 32'h2001_0005) begin errors++; $display("FAIL wrap1_instr got %h want %h", bus2.instruction, 32'h2001_0005); end
        checks++; if (bus2.instr_valid !== 1'b1) begin errors++; $display("FAIL wrap1_valid got %b want 1", bus2.instr_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = 32'h0;
        bus.imem_ready     = 1'b1;
        bus2.stall         = 1'b0;
        bus2.flush         = 1'b0;
        bus2.branch_taken  = 1'b0;
        bus2.branch_target = 32'h0;
        bus2.imem_ready    = 1'b1;
        #1;
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_not_ready();
        test_stall();
        test_branch_held();
        test_flush();
        test_zero_word();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 4-stage pipeline. Holds the program counter, fetches from instruction memory over a ready handshake, and presents one 32-bit instruction per cycle to the control decoder. Handles downstream stall, flush and branch redirect. Bubbles are always presented as the all-zero word, which the decoder treats as a NoOp.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset; 0 = in reset.
- Stall  input  1  hold PC and IF/ID contents.
- Flush  input  1  kill IF/ID contents (insert NoOp).
- BranchTaken  input  1  redirect fetch this cycle.
- BranchTarget  input  32  redirect address; bits [1:0] ignored and forced to 0.
- IMemReq  output  1  fetch request.
- IMemAddr  output  32  fetch address, equal to the current PC.
- IMemData  input  32  instruction word; valid only when IMemReady=1.
- IMemReady  input  1  transaction completes this cycle.
- Instruction  output  32  IF/ID instruction to the decoder.
- InstrPC  output  32  address of Instruction.
- InstrValid  output  1  1 = Instruction is a real fetched word.

## Operation
- State machine has two states:
  - FETCH: IMemReq=1.
  - HELD: IMemReq=0; a fetched word is parked in a one-entry skid buffer.
- Memory handshake:
  - A transaction completes only in a cycle where IMemReq=1 and IMemReady=1.
  - IMemAddr may change before completion (redirect); nothing is outstanding across edges.
- Per-edge priority, highest first: BranchTaken, Flush, Stall, normal.
- BranchTaken=1:
  - PC <= {BranchTarget[31:2],2'b00}.
  - IF/ID <= NoOp (Instruction=0, InstrValid=0, InstrPC=0).
  - Skid buffer discarded; same-cycle response discarded; state <= FETCH.
- Flush=1 (no branch):
  - IF/ID <= NoOp.
  - Same-cycle response discarded and PC unchanged, so the word is refetched.
  - Skid buffer discarded; state <= FETCH.
- Stall=1, state FETCH:
  - IF/ID and PC hold.
  - If a response completes, store IMemData in the skid buffer, PC <= PC+4 and state <= HELD.
- Stall=1, state HELD: everything holds.
- Normal operation (no Stall), state FETCH:
  - If a response completes: IF/ID <= {IMemData, PC, valid=1} and PC <= PC+4.
  - Otherwise IF/ID <= NoOp.
- Normal operation (no Stall), state HELD:
  - IF/ID <= {buffer, PC-4, valid=1}; state <= FETCH.
  - No fetch completes in this cycle because IMemReq=0.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- A fetched all-zero word is passed through with InstrValid=1.
- Reset values, applied asynchronously:
  - PC=RESET_PC, state=FETCH.
  - Instruction=0, InstrPC=0, InstrValid=0, skid buffer=0.
  - IMemReq=0 while Reset=0; IMemAddr=RESET_PC.

## Timing
- IMemReq and IMemAddr are combinational from state and PC.
- Instruction, InstrPC and InstrValid are registered.
- Fetch latency: a word completing in cycle N appears on Instruction in cycle N+1.
- With IMemReady tied to 1, throughput is one instruction per cycle.
- After Reset deasserts, the first rising edge captures the word at RESET_PC.
- Branch asserted in cycle N: IMemAddr=target in N+1, target word on Instruction in N+2, and a NoOp in N+1.
- Stall released after HELD: the buffered word appears on the next edge, then fetch resumes at PC.
- Reset asserted mid-transaction: the transaction is abandoned. IMemReq drops combinationally and all outputs take their reset values immediately.
- Simultaneous BranchTaken, Flush and Stall: branch behaviour only.

## Test plan
- Reset release, IMemReady=1, memory holding words 0x20010005, 0x00221820 at 0 and 4:
  - Instruction shows them on consecutive cycles with InstrPC 0 and 4, InstrValid=1.
- IMemReady low for 3 cycles at PC=8:
  - Three NoOp cycles (Instruction=0, InstrValid=0), then the word at 8; IMemAddr stays 8 throughout.
- Stall high for 4 cycles while a word at 0xC completes:
  - IF/ID holds; state goes to HELD with IMemReq=0.
  - On release, Instruction shows the 0xC word with InstrPC=0xC; the next fetch address is 0x10.
- BranchTaken with target 0x103 while stalled in HELD:
  - Buffer dropped; IMemAddr=0x100 next cycle; Instruction=0 for one cycle, then the word at 0x100.
- Flush while a word at 0x20 completes:
  - IF/ID shows a NoOp; next cycle IMemAddr=0x20 (refetch), and the 0x20 word follows.
- RESET_PC=32'hFFFF_FFFC:
  - First InstrPC is 0xFFFFFFFC, second is 0x0.
  - Reset asserted mid-run clears all outputs before the next edge.
